// File: rtl/sensor_conditioner_pkg.sv
// Shared definitions for the two-road traffic-light block family.
//  - Default timing constants for the loop-detector conditioner.
//  - Colour encodings used by the controller that consumes sens1/sens2.
//  - cnt_width(): counter width helper. It never returns less than 1 bit,
//    so HOLD=0 still yields a legal vector.
package sensor_conditioner_pkg;

  localparam int DEB_DEFAULT   = 3;   // sampled cycles a new raw level must persist
  localparam int HOLD_DEFAULT  = 4;   // presence stretch after the debounced fall
  localparam int STUCK_DEFAULT = 40;  // debounced-high cycles before declaring a fault

  typedef enum logic [1:0] {
    ROSSO  = 2'd0,
    GIALLO = 2'd1,
    VERDE  = 2'd2
  } colour_e;

  // Bits needed to hold 0..max_val, with a floor of one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Detector/presence bundle between the loop detectors and the controller.
//  raw1/raw2     : raw loop-detector lines (asynchronous, may bounce)
//  sens1/sens2   : conditioned presence, one per road
//  fault1/fault2 : stuck-detector flags, one per road
// master = stimulus/detector side, slave = the conditioner.
interface sensor_conditioner_if;
  logic raw1;
  logic raw2;
  logic sens1;
  logic sens2;
  logic fault1;
  logic fault2;

  modport master (
    output raw1, raw2,
    input  sens1, sens2, fault1, fault2
  );

  modport slave (
    input  raw1, raw2,
    output sens1, sens2, fault1, fault2
  );
endinterface

// File: rtl/sensor_conditioner_channel.sv
// One detector channel: 2-flop synchroniser, debounce, hold stretch and
// stuck-at-1 detection.
// Ports:
//  clock  in  : system clock, rising edge
//  reset_ in  : asynchronous reset, active high
//  raw    in  : raw loop-detector line
//  sens   out : registered conditioned presence
//  fault  out : registered stuck-detector flag
module sensor_channel
  import sensor_conditioner_pkg::*;
#(
  parameter int DEB   = DEB_DEFAULT,
  parameter int HOLD  = HOLD_DEFAULT,
  parameter int STUCK = STUCK_DEFAULT
) (
  input  logic clock,
  input  logic reset_,
  input  logic raw,
  output logic sens,
  output logic fault
);

  localparam int DW = cnt_width(DEB);
  localparam int HW = cnt_width(HOLD);
  localparam int SW = cnt_width(STUCK);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB - 1);
  localparam logic [DW-1:0] D_ONE    = DW'(1);
  localparam logic [HW-1:0] HOLD_V   = HW'(HOLD);
  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [SW-1:0] STUCK_V  = SW'(STUCK);
  localparam logic [SW-1:0] S_ONE    = SW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          st_q,    st_d;
  logic [DW-1:0] dcnt_q,  dcnt_d;
  logic [HW-1:0] hcnt_q,  hcnt_d;
  logic [SW-1:0] ocnt_q,  ocnt_d;
  logic          sens_q,  sens_d;
  logic          fault_q, fault_d;
  logic          at_stuck;

  // Next-state logic for the whole channel.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    st_d     = st_q;
    dcnt_d   = '0;
    hcnt_d   = '0;
    ocnt_d   = '0;
    at_stuck = (ocnt_q == STUCK_V);

    // Debounce: accept a new level only after DEB consecutive differing samples.
    if (sync2_q == st_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DEB_LAST) begin
      st_d   = sync2_q;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + D_ONE;
    end

    // Hold: load on the accepted fall unless the channel is faulted.
    if (st_q && !st_d) begin
      hcnt_d = at_stuck ? '0 : HOLD_V;
    end else if (st_q) begin
      hcnt_d = '0;
    end else if (hcnt_q != '0) begin
      hcnt_d = hcnt_q - H_ONE;
    end else begin
      hcnt_d = '0;
    end

    // Stuck counter: counts cycles with st high, saturating. It is cleared on
    // the same edge st falls so that fault drops exactly one edge later.
    if (!st_d) begin
      ocnt_d = '0;
    end else if (st_q && !at_stuck) begin
      ocnt_d = ocnt_q + S_ONE;
    end else begin
      ocnt_d = ocnt_q;
    end

    fault_d = at_stuck;
    sens_d  = !at_stuck && (st_q || (hcnt_q != '0));
  end

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset_) begin
    if (reset_) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      st_q    <= 1'b0;
      dcnt_q  <= '0;
      hcnt_q  <= '0;
      ocnt_q  <= '0;
      sens_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      st_q    <= st_d;
      dcnt_q  <= dcnt_d;
      hcnt_q  <= hcnt_d;
      ocnt_q  <= ocnt_d;
      sens_q  <= sens_d;
      fault_q <= fault_d;
    end
  end

  assign sens  = sens_q;
  assign fault = fault_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Two-channel loop-detector conditioner feeding the traffic-light controller.
// Wiring only: two independent sensor_channel instances.
// Ports:
//  clock  in  : system clock, rising edge
//  reset_ in  : asynchronous reset, active high
//  bus        : slave side of sensor_conditioner_if (raw in, sens/fault out)
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int DEB   = DEB_DEFAULT,
  parameter int HOLD  = HOLD_DEFAULT,
  parameter int STUCK = STUCK_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset_,
  sensor_conditioner_if.slave  bus
);

  sensor_channel #(.DEB(DEB), .HOLD(HOLD), .STUCK(STUCK)) u_ch1 (
    .clock  (clock),
    .reset_ (reset_),
    .raw    (bus.raw1),
    .sens   (bus.sens1),
    .fault  (bus.fault1)
  );

  sensor_channel #(.DEB(DEB), .HOLD(HOLD), .STUCK(STUCK)) u_ch2 (
    .clock  (clock),
    .reset_ (reset_),
    .raw    (bus.raw2),
    .sens   (bus.sens2),
    .fault  (bus.fault2)
  );

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner (DEB=3, HOLD=4, STUCK=40).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Edge numbers in tags count from the first edge that samples the new raw level.
module tb_sensor_conditioner;

  logic clock = 1'b0;
  logic reset_;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   seen;

  sensor_conditioner_if bus ();

  sensor_conditioner dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    // 1. Reset with both detectors already active.
    reset_   = 1'b1;
    bus.raw1 = 1'b1;
    bus.raw2 = 1'b1;
    cyc(3);
    check("t1_rst_sens1",  bus.sens1,  1'b0);
    check("t1_rst_sens2",  bus.sens2,  1'b0);
    check("t1_rst_fault1", bus.fault1, 1'b0);
    check("t1_rst_fault2", bus.fault2, 1'b0);
    reset_ = 1'b0;
    cyc(5);
    check("t1_e5_sens1", bus.sens1, 1'b0);
    check("t1_e5_sens2", bus.sens2, 1'b0);
    cyc(1);
    check("t1_e6_sens1", bus.sens1, 1'b1);
    check("t1_e6_sens2", bus.sens2, 1'b1);
    bus.raw1 = 1'b0;
    bus.raw2 = 1'b0;
    cyc(20);
    check("t1_idle_sens1", bus.sens1, 1'b0);
    check("t1_idle_sens2", bus.sens2, 1'b0);

    // 2. Two 2-cycle pulses with a 1-cycle gap never reach the debounce count.
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      bus.raw1 = (i == 0 || i == 1 || i == 3 || i == 4);
      cyc(1);
      if (bus.sens1) seen++;
    end
    check("t2_glitch_sens1", seen != 0, 1'b0);

    // 3. Clean 10-cycle pulse: rise at edge 6, fall at the 10th edge after raw fall.
    bus.raw1 = 1'b1;
    cyc(5);
    check("t3_rise_e5", bus.sens1, 1'b0);
    cyc(1);
    check("t3_rise_e6", bus.sens1, 1'b1);
    cyc(4);
    bus.raw1 = 1'b0;
    cyc(9);
    check("t3_fall_e9", bus.sens1, 1'b1);
    cyc(1);
    check("t3_fall_e10", bus.sens1, 1'b0);

    // 4. Short low window: st falls, hold covers the gap until st rises again.
    bus.raw1 = 1'b1;
    cyc(12);
    check("t4_pre_sens1", bus.sens1, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      bus.raw1 = (i >= 4);
      cyc(1);
      if (!bus.sens1) seen++;
    end
    check("t4_no_drop", seen != 0, 1'b0);
    bus.raw1 = 1'b0;
    cyc(15);
    check("t4_end_sens1",  bus.sens1,  1'b0);
    check("t4_end_fault1", bus.fault1, 1'b0);

    // 5. Stuck detector on road 2.
    bus.raw2 = 1'b1;
    cyc(5);
    check("t5_e5_sens2", bus.sens2, 1'b0);
    cyc(1);
    check("t5_e6_sens2", bus.sens2, 1'b1);
    cyc(39);
    check("t5_e45_sens2",  bus.sens2,  1'b1);
    check("t5_e45_fault2", bus.fault2, 1'b0);
    cyc(1);
    check("t5_e46_sens2",  bus.sens2,  1'b0);
    check("t5_e46_fault2", bus.fault2, 1'b1);
    check("t5_e46_sens1",  bus.sens1,  1'b0);
    check("t5_e46_fault1", bus.fault1, 1'b0);
    cyc(4);
    check("t5_e50_fault2", bus.fault2, 1'b1);
    bus.raw2 = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      if (bus.sens2) seen++;
      if (i == 4) check("t5_rel_e5_fault2", bus.fault2, 1'b1);
      if (i == 5) check("t5_rel_e6_fault2", bus.fault2, 1'b0);
    end
    check("t5_no_stretch", seen != 0, 1'b0);

    // 6. Reset pulse mid-hold, then independent channel-2 activity.
    bus.raw1 = 1'b1;
    cyc(12);
    bus.raw1 = 1'b0;
    cyc(7);
    check("t6_mid_hold_sens1", bus.sens1, 1'b1);
    #2;
    reset_ = 1'b1;
    #1;
    check("t6_async_sens1",  bus.sens1,  1'b0);
    check("t6_async_fault1", bus.fault1, 1'b0);
    @(negedge clock);
    reset_   = 1'b0;
    bus.raw2 = 1'b1;
    cyc(5);
    check("t6_e5_sens2", bus.sens2, 1'b0);
    cyc(1);
    check("t6_e6_sens2", bus.sens2, 1'b1);
    check("t6_e6_sens1", bus.sens1, 1'b0);
    bus.raw2 = 1'b0;
    cyc(9);
    check("t6_fall_e9_sens2", bus.sens2, 1'b1);
    cyc(1);
    check("t6_fall_e10_sens2", bus.sens2, 1'b0);
    check("t6_end_sens1",      bus.sens1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
